// File: rtl/dcache_pkg.sv
// dcache_pkg: shared widths, tag-entry bit positions, FSM states and a word-merge helper
package dcache_pkg;
    localparam int TAG_W    = 23;
    localparam int IDX_W    = 4;
    localparam int OFF_W    = 5;
    localparam int LINE_W   = 256;
    localparam int NUM_SETS = 1 << IDX_W;
    localparam int ENTRY_W  = TAG_W + 2;
    localparam int VALID_B  = 24;
    localparam int DIRTY_B  = 23;

    typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

    function automatic logic [LINE_W-1:0] merge_word(
        input logic [LINE_W-1:0] line,
        input logic [2:0]        w,
        input logic [31:0]       d
    );
        logic [LINE_W-1:0] r;
        r = line;
        r[{w, 5'b0} +: 32] = d;
        return r;
    endfunction
endpackage

// File: rtl/dcache_way_match.sv
// dcache_way_match: per-way tag compare; way0 wins when both ways match
module dcache_way_match
    import dcache_pkg::*;
(
    input  logic [ENTRY_W-1:0] tag0,
    input  logic [ENTRY_W-1:0] tag1,
    input  logic [TAG_W-1:0]   req_tag,
    output logic [1:0]         way_sel,
    output logic               hit
);
    logic m0, m1;

    assign m0      = tag0[VALID_B] && tag0[TAG_W-1:0] == req_tag;
    assign m1      = tag1[VALID_B] && tag1[TAG_W-1:0] == req_tag;
    assign way_sel = {m1 & ~m0, m0};
    assign hit     = m0 | m1;
endmodule

// File: rtl/dcache_2way_ctrl.sv
// dcache_2way_ctrl: 2-way write-back/write-allocate cache controller; DCACHE_STATS_EN adds hit/miss counters
module dcache_2way_ctrl
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);
    state_t state, next_state;
    logic [ENTRY_W-1:0] tags0 [NUM_SETS];
    logic [ENTRY_W-1:0] tags1 [NUM_SETS];
    logic [LINE_W-1:0]  data0 [NUM_SETS];
    logic [LINE_W-1:0]  data1 [NUM_SETS];
    logic [NUM_SETS-1:0] lru;
    logic [31:0] req_addr, req_data, a_addr, a_data;
    logic        req_we, victim, a_we, idle, miss, access, fill_ack, v_way, hit;
    logic [IDX_W-1:0]   idx;
    logic [2:0]         word;
    logic [TAG_W-1:0]   tag;
    logic [1:0]         way_sel;
    logic [ENTRY_W-1:0] v_entry;
    logic [LINE_W-1:0]  v_line, hit_line;

    // Outside IDLE the latched request drives the lookup, so DONE replays it as a hit
    assign idle     = state == IDLE;
    assign a_addr   = idle ? cpu_addr_i : req_addr;
    assign a_data   = idle ? cpu_data_i : req_data;
    assign a_we     = idle ? cpu_we_i : req_we;
    assign idx      = a_addr[OFF_W +: IDX_W];
    assign word     = a_addr[4:2];
    assign tag      = a_addr[31 -: TAG_W];
    assign v_way    = idle ? lru[idx] : victim;
    assign v_entry  = v_way ? tags1[idx] : tags0[idx];
    assign v_line   = v_way ? data1[idx] : data0[idx];
    assign hit_line = way_sel[1] ? data1[idx] : data0[idx];

    dcache_way_match u_match (
        .tag0    (tags0[idx]),
        .tag1    (tags1[idx]),
        .req_tag (tag),
        .way_sel (way_sel),
        .hit     (hit)
    );

    assign miss        = idle & cpu_req_i & ~hit;
    assign access      = (idle & cpu_req_i & hit) | (state == DONE);
    assign fill_ack    = (state == FILL) & mem_ack_i;
    assign cpu_data_o  = hit_line[{word, 5'b0} +: 32];
    assign cpu_stall_o = ~idle | (cpu_req_i & ~hit);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (miss) next_state = (v_entry[VALID_B] & v_entry[DIRTY_B]) ? WB : FILL;
            WB:      if (mem_ack_i) next_state = FILL;
            FILL:    if (mem_ack_i) next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_enable_o = (state == WB) | (state == FILL);
        mem_write_o  = state == WB;
        mem_addr_o   = (state == WB)   ? {v_entry[TAG_W-1:0], idx, 5'b0} :
                       (state == FILL) ? {req_addr[31:5], 5'b0} : '0;
        mem_data_o   = (state == WB) ? v_line : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                tags0[i] <= '0;
                tags1[i] <= '0;
            end
            lru      <= '0;
            req_addr <= '0;
            req_data <= '0;
            req_we   <= 1'b0;
            victim   <= 1'b0;
        end else begin
            if (miss) begin
                req_addr <= cpu_addr_i;
                req_data <= cpu_data_i;
                req_we   <= cpu_we_i;
                victim   <= lru[idx];
            end
            if (fill_ack && victim)  tags1[idx] <= {2'b10, tag};
            if (fill_ack && !victim) tags0[idx] <= {2'b10, tag};
            if (access) lru[idx] <= way_sel[0];
            if (access && a_we && way_sel[0]) tags0[idx][DIRTY_B] <= 1'b1;
            if (access && a_we && way_sel[1]) tags1[idx][DIRTY_B] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_ack && victim)  data1[idx] <= mem_data_i;
        if (fill_ack && !victim) data0[idx] <= mem_data_i;
        if (access && a_we && way_sel[0]) data0[idx] <= merge_word(data0[idx], word, a_data);
        if (access && a_we && way_sel[1]) data1[idx] <= merge_word(data1[idx], word, a_data);
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (idle && cpu_req_i) begin
            if (hit) hit_cnt_o  <= hit_cnt_o + 1'b1;
            else     miss_cnt_o <= miss_cnt_o + 1'b1;
        end
    end
`endif
endmodule
